// File: rtl/image_sender.sv
// Host-side image transmitter: streams a 14x14 binary image as 28 7-bit chunks and captures the BCD result.
// Optional WAIT abort counter enabled by defining IMAGE_SENDER_TIMEOUT_EN.
module image_sender #(
  parameter int SYNC_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [195:0] image_in,
  input  logic         done_flag,
  input  logic [3:0]   result_bcd,
  output logic [6:0]   data_out,
  output logic         frame_flag,
  output logic         busy,
  output logic [3:0]   result,
  output logic         result_valid,
  output logic         timeout
);

  // state | meaning
  // IDLE  | waiting for start, reader held in reset
  // SYNC  | frame_flag low for SYNC_CYCLES so the reader resyncs
  // SEND  | streaming 28 chunks, LSB chunk first
  // WAIT  | frame_flag held high until done_flag (or abort)
  typedef enum logic [1:0] {IDLE, SYNC, SEND, WAIT} state_t;

  // One shared down-counter covers both the SYNC hold and the WAIT abort count.
  localparam int CNT_MAX = (SYNC_CYCLES > TIMEOUT) ? SYNC_CYCLES : TIMEOUT;
  localparam int TMR_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [TMR_W-1:0] SYNC_LOAD = TMR_W'(SYNC_CYCLES - 1);
`ifdef IMAGE_SENDER_TIMEOUT_EN
  localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(TIMEOUT - 1);
`endif

  state_t             state, state_nx;
  logic [195:0]       shreg, shreg_nx;
  logic [4:0]         chunk_cnt, chunk_cnt_nx;
  logic [TMR_W-1:0]   tmr, tmr_nx;
  logic [6:0]         data_nx;
  logic               frame_nx, busy_nx, valid_nx, timeout_nx;
  logic [3:0]         result_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      chunk_cnt    <= '0;
      tmr          <= '0;
      data_out     <= '0;
      frame_flag   <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      shreg        <= shreg_nx;
      chunk_cnt    <= chunk_cnt_nx;
      tmr          <= tmr_nx;
      data_out     <= data_nx;
      frame_flag   <= frame_nx;
      busy         <= busy_nx;
      result       <= result_nx;
      result_valid <= valid_nx;
      timeout      <= timeout_nx;
    end
  end

  // Outputs are computed for the next state so every pin comes straight off a flop.
  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    chunk_cnt_nx = chunk_cnt;
    tmr_nx       = tmr;
    data_nx      = '0;
    frame_nx     = 1'b0;
    busy_nx      = 1'b1;
    result_nx    = result;
    valid_nx     = 1'b0;
    timeout_nx   = 1'b0;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          shreg_nx     = image_in;
          chunk_cnt_nx = '0;
          tmr_nx       = SYNC_LOAD;
          busy_nx      = 1'b1;
          state_nx     = SYNC;
        end
      end
      SYNC: begin
        if (tmr == '0) begin
          frame_nx     = 1'b1;
          data_nx      = shreg[6:0];
          shreg_nx     = shreg >> 7;
          chunk_cnt_nx = 5'd27;
          state_nx     = SEND;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      SEND: begin
        frame_nx = 1'b1;
        if (chunk_cnt == '0) begin
          state_nx = WAIT;
`ifdef IMAGE_SENDER_TIMEOUT_EN
          tmr_nx   = WAIT_LOAD;
`endif
        end else begin
          data_nx      = shreg[6:0];
          shreg_nx     = shreg >> 7;
          chunk_cnt_nx = chunk_cnt - 1'b1;
        end
      end
      WAIT: begin
        frame_nx = 1'b1;
        if (done_flag) begin
          result_nx = result_bcd;
          valid_nx  = 1'b1;
          busy_nx   = 1'b0;
          frame_nx  = 1'b0;
          state_nx  = IDLE;
        end
`ifdef IMAGE_SENDER_TIMEOUT_EN
        else if (tmr == '0) begin
          timeout_nx = 1'b1;
          busy_nx    = 1'b0;
          frame_nx   = 1'b0;
          state_nx   = IDLE;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
`endif
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_image_sender.sv
// Directed self-checking bench for image_sender (SYNC_CYCLES=2, TIMEOUT=4).
module tb_image_sender;
  localparam int SYNC = 2;
  localparam int TOUT = 4;

  logic         clk = 1'b0;
  logic         reset, start, done_flag;
  logic [195:0] image_in;
  logic [3:0]   result_bcd;
  logic [6:0]   data_out;
  logic         frame_flag, busy, result_valid, timeout;
  logic [3:0]   result;

  int n_vec = 0;
  int n_err = 0;

  image_sender #(.SYNC_CYCLES(SYNC), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .image_in(image_in),
    .done_flag(done_flag), .result_bcd(result_bcd), .data_out(data_out),
    .frame_flag(frame_flag), .busy(busy), .result(result),
    .result_valid(result_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},    32'(data_out), 0);
    chk({tag, "_frame"},   32'(frame_flag), 0);
    chk({tag, "_busy"},    32'(busy), 0);
    chk({tag, "_result"},  32'(result), 0);
    chk({tag, "_valid"},   32'(result_valid), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  // Starts a frame from IDLE and checks SYNC and every chunk; ends in the first WAIT cycle
  // unless stop_at aborts after that chunk. inject_at pulses start with another image.
  task automatic stream(input logic [195:0] img, input int inject_at, input int stop_at);
    logic [195:0] m;
    m = img;
    image_in = img;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sync_busy",  32'(busy), 1);
    chk("sync_frame", 32'(frame_flag), 0);
    chk("sync_data",  32'(data_out), 0);
    for (int s = 1; s < SYNC; s++) begin
      tick();
      chk("sync_hold_frame", 32'(frame_flag), 0);
      chk("sync_hold_data",  32'(data_out), 0);
    end
    for (int k = 0; k < 28; k++) begin
      tick();
      start = 1'b0;
      chk($sformatf("chunk%0d", k), 32'(data_out), 32'(m[6:0]));
      chk($sformatf("chunk%0d_frame", k), 32'(frame_flag), 1);
      chk($sformatf("chunk%0d_valid", k), 32'(result_valid), 0);
      m = m >> 7;
      if (k == stop_at) return;
      if (k == inject_at) begin
        start = 1'b1;
        image_in = ~img;
      end
    end
    tick();
    chk("wait_data",  32'(data_out), 0);
    chk("wait_frame", 32'(frame_flag), 1);
    chk("wait_busy",  32'(busy), 1);
  endtask

  initial begin
    logic [195:0] img;
    reset = 1'b1; start = 1'b0; done_flag = 1'b0; result_bcd = 4'd0; image_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk_all_zero("rst");

    // single frame, done 5 cycles into WAIT
    stream(196'd9, -1, -1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_hold_busy",  32'(busy), 1);
      chk("wait_hold_valid", 32'(result_valid), 0);
    end
    done_flag = 1'b1; result_bcd = 4'd9;
    tick();
    done_flag = 1'b0;
    chk("single_valid",  32'(result_valid), 1);
    chk("single_result", 32'(result), 9);
    chk("single_busy",   32'(busy), 0);
    chk("single_frame",  32'(frame_flag), 0);
    tick();
    chk("single_valid_pulse", 32'(result_valid), 0);
    chk("single_result_hold", 32'(result), 9);

    // chunk order: chunk k = k+1
    img = '0;
    for (int k = 0; k < 28; k++) img[7*k +: 7] = 7'(k + 1);
    stream(img, -1, -1);
    done_flag = 1'b1; result_bcd = 4'd2;
    tick();
    done_flag = 1'b0;
    chk("order_result", 32'(result), 2);
    tick();

    // start while busy is ignored
    img = {4{49'h1_2345_6789_ABCD}};
    stream(img, 5, -1);
    done_flag = 1'b1; result_bcd = 4'd5;
    tick();
    done_flag = 1'b0;
    chk("busy_start_result", 32'(result), 5);
    chk("busy_start_valid",  32'(result_valid), 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("no_second_busy",  32'(busy), 0);
      chk("no_second_frame", 32'(frame_flag), 0);
    end

    // stale done ignored until WAIT
    done_flag = 1'b1; result_bcd = 4'd3;
    stream({7{28'hA5C_3F19}}, -1, -1);
    chk("stale_wait_valid",  32'(result_valid), 0);
    chk("stale_wait_result", 32'(result), 5);
    tick();
    done_flag = 1'b0;
    chk("stale_valid",  32'(result_valid), 1);
    chk("stale_result", 32'(result), 3);
    chk("stale_busy",   32'(busy), 0);
    tick();

    // reset mid-SEND at chunk 10, start coinciding with reset
    img = {14{14'h2B6D}};
    stream(img, -1, 10);
    reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    tick();
    start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk_all_zero("midrst_end");
    tick();
    chk("rst_beats_start_busy", 32'(busy), 0);
    stream(img, -1, -1);
    done_flag = 1'b1; result_bcd = 4'd7;
    tick();
    done_flag = 1'b0;
    chk("after_rst_result", 32'(result), 7);
    tick();

    // WAIT without done
    stream(196'h3, -1, -1);
`ifdef IMAGE_SENDER_TIMEOUT_EN
    for (int i = 0; i < TOUT - 1; i++) begin
      tick();
      chk("to_pending", 32'(timeout), 0);
      chk("to_pending_busy", 32'(busy), 1);
    end
    tick();
    chk("to_pulse",  32'(timeout), 1);
    chk("to_busy",   32'(busy), 0);
    chk("to_frame",  32'(frame_flag), 0);
    chk("to_result", 32'(result), 7);
    chk("to_valid",  32'(result_valid), 0);
    tick();
    chk("to_pulse_end", 32'(timeout), 0);
`else
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_to",       32'(timeout), 0);
      chk("no_to_busy",  32'(busy), 1);
      chk("no_to_frame", 32'(frame_flag), 1);
    end
    done_flag = 1'b1; result_bcd = 4'd1;
    tick();
    done_flag = 1'b0;
    chk("late_done_result", 32'(result), 1);
    chk("late_done_valid",  32'(result_valid), 1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/image_sender.md
# image_sender

Host-side transmitter for the accelerator's image-row input protocol. It takes a 196-bit 14x14 binary image, then drives the frame flag and 28 consecutive 7-bit chunks into the accelerator input pins. It waits for the classification-complete flag and captures the 4-bit BCD result. It replaces the Raspberry Pi driver in FPGA bring-up and serves as the stimulus engine in system-level benches.

## Interface

Parameters:
- `SYNC_CYCLES`, default 2: cycles `frame_flag` is held low before streaming (reader resync). Legal range is 2 or more.
- `TIMEOUT`, default 255: maximum WAIT cycles before abort. Legal range is 1 to 65535.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request to send `image_in`. Sampled only in IDLE.
- `image_in` input 196: image to send. Captured on the accepted `start`.
- `done_flag` input 1: accelerator classification-complete flag (accelerator `uo_out[7]`).
- `result_bcd` input 4: accelerator BCD result (accelerator `uio_out[3:0]`).
- `data_out` output 7: chunk bus, drives accelerator `ui_in[6:0]`.
- `frame_flag` output 1: drives accelerator `ui_in[7]`. Low = reader held in reset; high = reading.
- `busy` output 1: high from the cycle after an accepted `start` until return to IDLE.
- `result` output 4: last captured classification. Holds until the next capture.
- `result_valid` output 1: one-cycle pulse when `result` is updated.
- `timeout` output 1: one-cycle pulse on WAIT abort.

## Operation

- FSM states: IDLE, SYNC, SEND, WAIT.
- IDLE:
  - `frame_flag`=0, `data_out`=0, `busy`=0.
  - `start`=1 latches `image_in` into a 196-bit shift register, clears the counter, and enters SYNC.
- SYNC:
  - `frame_flag`=0 and `data_out`=0 for `SYNC_CYCLES` cycles, then enter SEND.
- SEND:
  - `frame_flag`=1.
  - Chunk k (k=0..27) is `image_in[7k+6:7k]`: LSB chunk first, one chunk per cycle. The shift register moves right by 7 each cycle.
  - After chunk 27, enter WAIT.
- WAIT:
  - `frame_flag` stays 1 (the reader must not be reset while the accelerator classifies). `data_out`=0.
  - On the first cycle `done_flag`=1: capture `result_bcd` into `result`, pulse `result_valid`, enter IDLE.
- `done_flag` is ignored outside WAIT. A stale flag from the previous frame is cleared by the SYNC low period.
- `start` is ignored while `busy`=1. No queueing.
- Counter: 5 bits for chunk index; up to 16 bits for SYNC and WAIT counts, sized by parameter.
- Reset at any point forces IDLE:
  - `data_out`=0, `frame_flag`=0, `busy`=0, `result`=0, `result_valid`=0, `timeout`=0.
  - Counter and shift register are cleared.
  - A partial frame is abandoned. The accelerator sees `frame_flag` low and resyncs.

## Timing

- All outputs are registered.
- `start` is sampled at edge T. Then:
  - `busy`=1 from T+1.
  - SYNC occupies T+1 .. T+`SYNC_CYCLES`.
  - Chunk 0 is valid on `data_out` during cycle T+`SYNC_CYCLES`+1.
  - Chunk 27 is valid during T+`SYNC_CYCLES`+28.
  - WAIT begins at T+`SYNC_CYCLES`+29.
- `frame_flag` rises in the same cycle chunk 0 appears.
- If `done_flag` is sampled high at edge W in WAIT, then at W+1:
  - `result` updates and `result_valid`=1 for exactly one cycle.
  - `busy`=0 and `frame_flag`=0.
- A new `start` is accepted at W+1 at the earliest. Back-to-back frames therefore take `SYNC_CYCLES`+30 cycles each, excluding accelerator latency.
- `start` and `reset` in the same cycle: reset wins.

## Configuration

- `IMAGE_SENDER_TIMEOUT_EN` defined:
  - The WAIT counter is compiled in.
  - After `TIMEOUT` consecutive WAIT cycles without `done_flag`, `timeout` pulses one cycle and the FSM enters IDLE.
  - On timeout, `frame_flag` drops to 0 and `result` is unchanged.
  - `done_flag` arriving on the same edge the count expires is treated as success; no timeout.
- Not defined:
  - WAIT waits indefinitely.
  - `timeout` is tied to 0.
  - No WAIT counter logic is present.

## Test plan

- Reset defaults: hold `reset` high for 3 cycles mid-SEND (chunk 10) -> next cycle all outputs 0, state IDLE, `frame_flag`=0; a new `start` then sends a full 28-chunk frame.
- Single frame: `image_in`=196'd9, `start` pulse, `done_flag` high 5 cycles into WAIT with `result_bcd`=9 -> `frame_flag` low for 2 cycles, then `data_out`=7'd9 followed by 27 zero chunks, `result`=9, `result_valid` one pulse.
- Chunk order: `image_in` with chunk k = k+1 -> `data_out` sequence 1,2,...,28 on consecutive cycles with `frame_flag`=1 throughout.
- Start while busy: pulse `start` during SEND with a different image -> ignored; chunks are unchanged and no second frame follows.
- Stale done: `done_flag` held 1 through SYNC and SEND, with `result_bcd`=3 -> no capture before WAIT; capture of 3 at the first WAIT cycle +1.
- Timeout (macro defined, `TIMEOUT`=4): `done_flag` held 0 -> `timeout` pulses 4 cycles into WAIT, `result` unchanged, `busy`=0 the same cycle.
